// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: merges pipeline results with buffered divider results.
// Define WB_STARVE_GUARD_EN to stall the pipeline when the divider FIFO head is starved.
module wb_arbiter #(
   parameter int unsigned FIFO_DEPTH   = 2,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        pipe_reg_write_i,
   input  logic [4:0]                  pipe_rd_addr_i,
   input  logic [31:0]                 pipe_data_i,
   input  logic                        div_valid_i,
   input  logic [4:0]                  div_rd_addr_i,
   input  logic [31:0]                 div_data_i,
   output logic                        div_ready_o,
   input  logic [4:0]                  hz_rs1_addr_i,
   input  logic [4:0]                  hz_rs2_addr_i,
   output logic                        hz_stall_o,
   output logic                        wb_reg_write_o,
   output logic [4:0]                  wb_rd_addr_o,
   output logic [31:0]                 wb_data_o,
   output logic                        pipe_stall_o,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_param_check
      $error("wb_arbiter: FIFO_DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
   end

   logic [4:0]    ent_rd_q   [FIFO_DEPTH];
   logic [4:0]    ent_rd_d   [FIFO_DEPTH];
   logic [31:0]   ent_data_q [FIFO_DEPTH];
   logic [31:0]   ent_data_d [FIFO_DEPTH];
   logic          ent_live_q [FIFO_DEPTH];
   logic          ent_live_d [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic          wb_reg_write_q, wb_reg_write_d;
   logic [4:0]    wb_rd_addr_q, wb_rd_addr_d;
   logic [31:0]   wb_data_q, wb_data_d;
   logic          wb_from_div_q, wb_from_div_d;

   logic pipe_wr, enq, pop, fifo_empty;
   logic hit1, hit2;

   assign div_ready_o    = (count_q < CW'(FIFO_DEPTH));
   assign fifo_empty     = (count_q == '0);
   assign pipe_wr        = pipe_reg_write_i && (pipe_rd_addr_i != '0);
   assign enq            = div_valid_i && div_ready_o && (div_rd_addr_i != '0);
   assign pop            = !pipe_wr && !fifo_empty;

   assign wb_reg_write_o = wb_reg_write_q;
   assign wb_rd_addr_o   = wb_rd_addr_q;
   assign wb_data_o      = wb_data_q;
   assign fifo_count_o   = count_q;

   always_comb begin
      ent_rd_d   = ent_rd_q;
      ent_data_d = ent_data_q;
      ent_live_d = ent_live_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;

      // Live bits double as occupancy for the hazard check, so a pop clears its slot.
      if (pipe_wr) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (ent_rd_q[i] == pipe_rd_addr_i) ent_live_d[i] = 1'b0;
         end
      end
      if (pop) begin
         ent_live_d[rd_ptr_q] = 1'b0;
         rd_ptr_d             = rd_ptr_q + 1'b1;
      end
      if (enq) begin
         ent_rd_d[wr_ptr_q]   = div_rd_addr_i;
         ent_data_d[wr_ptr_q] = div_data_i;
         ent_live_d[wr_ptr_q] = !(pipe_wr && (pipe_rd_addr_i == div_rd_addr_i));
         wr_ptr_d             = wr_ptr_q + 1'b1;
      end
      if (enq && !pop)      count_d = count_q + 1'b1;
      else if (!enq && pop) count_d = count_q - 1'b1;
   end

   always_comb begin
      wb_reg_write_d = 1'b0;
      wb_rd_addr_d   = wb_rd_addr_q;
      wb_data_d      = wb_data_q;
      wb_from_div_d  = 1'b0;
      if (pipe_wr) begin
         wb_reg_write_d = 1'b1;
         wb_rd_addr_d   = pipe_rd_addr_i;
         wb_data_d      = pipe_data_i;
      end else if (pop) begin
         wb_reg_write_d = ent_live_q[rd_ptr_q];
         wb_rd_addr_d   = ent_rd_q[rd_ptr_q];
         wb_data_d      = ent_data_q[rd_ptr_q];
         wb_from_div_d  = 1'b1;
      end
   end

   always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
         if (ent_live_q[i] && (ent_rd_q[i] == hz_rs1_addr_i)) hit1 = 1'b1;
         if (ent_live_q[i] && (ent_rd_q[i] == hz_rs2_addr_i)) hit2 = 1'b1;
      end
      if (wb_reg_write_q && wb_from_div_q && (wb_rd_addr_q == hz_rs1_addr_i)) hit1 = 1'b1;
      if (wb_reg_write_q && wb_from_div_q && (wb_rd_addr_q == hz_rs2_addr_i)) hit2 = 1'b1;
      hz_stall_o = (hit1 && (hz_rs1_addr_i != '0)) || (hit2 && (hz_rs2_addr_i != '0));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            ent_rd_q[i]   <= '0;
            ent_data_q[i] <= '0;
            ent_live_q[i] <= 1'b0;
         end
         rd_ptr_q       <= '0;
         wr_ptr_q       <= '0;
         count_q        <= '0;
         wb_reg_write_q <= 1'b0;
         wb_rd_addr_q   <= '0;
         wb_data_q      <= '0;
         wb_from_div_q  <= 1'b0;
      end else begin
         ent_rd_q       <= ent_rd_d;
         ent_data_q     <= ent_data_d;
         ent_live_q     <= ent_live_d;
         rd_ptr_q       <= rd_ptr_d;
         wr_ptr_q       <= wr_ptr_d;
         count_q        <= count_d;
         wb_reg_write_q <= wb_reg_write_d;
         wb_rd_addr_q   <= wb_rd_addr_d;
         wb_data_q      <= wb_data_d;
         wb_from_div_q  <= wb_from_div_d;
      end
   end

`ifdef WB_STARVE_GUARD_EN
   localparam int unsigned SCW = $clog2(STARVE_LIMIT + 1);

   logic [SCW-1:0] starve_q, starve_d;
   logic           pipe_stall_q, pipe_stall_d;

   assign pipe_stall_o = pipe_stall_q;

   // Pipe win and pop are exclusive while non-empty, so the else path covers pop and empty.
   always_comb begin
      starve_d     = '0;
      pipe_stall_d = 1'b0;
      if (!fifo_empty && pipe_wr) begin
         if (starve_q == SCW'(STARVE_LIMIT - 1)) pipe_stall_d = 1'b1;
         else                                    starve_d     = starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_q     <= '0;
         pipe_stall_q <= 1'b0;
      end else begin
         starve_q     <= starve_d;
         pipe_stall_q <= pipe_stall_d;
      end
   end
`else
   assign pipe_stall_o = 1'b0;
`endif

endmodule
